multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control unit for the multicycle RV32I core, replacing the single-cycle main decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback. It drives the shared-memory, ALU-mux and register-file enables of the multicycle datapath. Parameters enable JALR, LUI/AUIPC and a variable-latency memory handshake that the single-cycle decoder has no equivalent for.

## Interface
- EN_JALR, default 1: JALR (1100111) supported; when 0 the opcode is illegal.
- EN_UPPER, default 1: LUI (0110111) and AUIPC (0010111) supported; when 0 both are illegal.
- MEM_WAIT, default 1: honour mem_ready_i; when 0, mem_ready_i is ignored and treated as constant 1.
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- op_i  in  7  opcode field from the instruction register, stable from DECODE onward.
- mem_ready_i  in  1  memory completes the current access this cycle.
- mem_req_o  out  1  memory access requested.
- adrsrc_o  out  1  memory address select: 0 = PC, 1 = Result.
- memwrite_o  out  1  memory write.
- irwrite_o  out  1  load the instruction register.
- pcupdate_o  out  1  unconditional PC write.
- branch_o  out  1  PC write if the ALU zero flag is set.
- regwrite_o  out  1  register-file write.
- resultsrc_o  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alusrca_o  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 reg, 11 = zero.
- alusrcb_o  out  2  ALU B select: 00 = rs2 reg, 01 = ImmExt, 10 = constant 4.
- aluop_o  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
- immsrc_o  out  3  immediate type: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- illegal_o  out  1  sticky illegal-opcode flag.
- state_o  out  4  current state, for debug.

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, JALR 11, UPPER 12, ILLEGAL 15. Codes 13 and 14 are unused and go to FETCH.
- Outputs are Moore, driven from the state only. Exceptions:
  - immsrc_o is decoded from op_i in every state: lw/I-ALU/jalr → I; sw → S; beq → B; jal → J; lui/auipc → U; otherwise 000.
  - UPPER's alusrca_o depends on op_i, as listed below.
- Every output not listed for a state is 0.
- **FETCH**: mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10.
  - irwrite and pcupdate are asserted only in the cycle mem_ready_i=1.
  - Stay in FETCH until ready, then go to DECODE.
- **DECODE**: alusrca=01, alusrcb=01, aluop=00 (branch/jump target into ALUOut). Next state by op_i:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 or 0010111 → UPPER
  - anything else, or a disabled opcode → ILLEGAL
- **MEMADR**: alusrca=10, alusrcb=01, aluop=00. Go to MEMREAD if op_i[5]=0, else MEMWRITE.
- **MEMREAD**: mem_req=1, adrsrc=1, resultsrc=00. Wait for ready, then go to MEMWB.
- **MEMWB**: resultsrc=01, regwrite=1, then go to FETCH.
- **MEMWRITE**: mem_req=1, adrsrc=1, resultsrc=00, memwrite=1 for the whole state; the memory commits on the ready cycle. Wait for ready, then go to FETCH.
- **EXECUTER**: alusrca=10, alusrcb=00, aluop=10, then go to ALUWB.
- **EXECUTEI**: alusrca=10, alusrcb=01, aluop=10, then go to ALUWB.
- **ALUWB**: resultsrc=00, regwrite=1, then go to FETCH.
- **BEQ**: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1, then go to FETCH.
- **JAL**: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1. PC takes ALUOut; ALUOut takes OldPC+4. Then go to ALUWB.
- **JALR**: alusrca=10, alusrcb=01, aluop=00 (rs1+imm into ALUOut), then go to JAL. Clearing bit 0 of the target is done in the datapath.
- **UPPER**: alusrca=11 if op_i[5]=1 (LUI), 01 if op_i[5]=0 (AUIPC); alusrcb=01, aluop=00. Then go to ALUWB.
- **ILLEGAL**: illegal_o=1 and all enables 0. The FSM stays in ILLEGAL until reset.

## Timing
- Reset:
  - While rst_i=1, the next state is FETCH.
  - irwrite, pcupdate, regwrite, memwrite and mem_req are forced to 0; the other outputs show FETCH values.
  - The first fetch request is in the cycle after rst_i falls.
- Reset during a memory wait aborts the access: mem_req and memwrite drop in the same cycle and the FSM returns to FETCH.
- mem_ready_i is sampled only in FETCH, MEMREAD and MEMWRITE; a ready pulse in any other state has no effect.
- mem_ready_i=1 in the first cycle of a wait state gives zero wait cycles.
- Cycles per instruction with zero memory wait: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4, jalr 5, lui/auipc 4. Each memory wait cycle adds 1.
- Memory-side handshake: a request stays asserted, with stable adrsrc and memwrite, until the ready cycle.

## Test plan
- Reset with MEM_WAIT=1 and ready held at 1: state_o=0, all enables 0 during reset; the first cycle after reset has mem_req=1, irwrite=1, pcupdate=1.
- lw (0000011) with 2 wait cycles on fetch and 1 on read: state sequence 0,0,0,1,2,3,3,4,0; regwrite=1 only in state 4 with resultsrc=01.
- sw with zero wait: sequence 0,1,2,5,0; memwrite=1 for exactly one cycle; regwrite never set.
- jalr with EN_JALR=1: sequence 0,1,11,10,8,0; pcupdate in states 0 and 10.
- Same jalr with EN_JALR=0: DECODE goes to 15; illegal_o stays 1 with ready toggling and any op_i, until rst_i.
- lui followed by auipc: UPPER shows alusrca=11 then 01, immsrc=100 in both; auipc with EN_UPPER=0 goes to ILLEGAL.
- Assert rst_i during a MEMWRITE wait: memwrite drops in the same cycle and state_o=0 next cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and drives the multicycle datapath enables.
module multicycle_ctrl #(
  parameter bit EN_JALR  = 1'b1,
  parameter bit EN_UPPER = 1'b1,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       adrsrc_o,
  output logic       memwrite_o,
  output logic       irwrite_o,
  output logic       pcupdate_o,
  output logic       branch_o,
  output logic       regwrite_o,
  output logic [1:0] resultsrc_o,
  output logic [1:0] alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] aluop_o,
  output logic [2:0] immsrc_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_UPPER    = 4'd12,
    S_ILLEGAL  = 4'd15
  } state_e;

  state_e state_q, state_d, out_state;
  logic   ready;

  assign ready   = MEM_WAIT ? mem_ready_i : 1'b1;
  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op_i)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECUTER;
          7'b0010011:             state_d = S_EXECUTEI;
          7'b1100011:             state_d = S_BEQ;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = EN_JALR ? S_JALR : S_ILLEGAL;
          7'b0110111, 7'b0010111: state_d = EN_UPPER ? S_UPPER : S_ILLEGAL;
          default:                state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = op_i[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ready) state_d = S_MEMWB;
      S_MEMWRITE: if (ready) state_d = S_FETCH;
      S_MEMWB, S_ALUWB, S_BEQ:            state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_UPPER:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JAL;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    immsrc_o = 3'b000;
    case (op_i)
      7'b0100011:             immsrc_o = 3'b001;
      7'b1100011:             immsrc_o = 3'b010;
      7'b1101111:             immsrc_o = 3'b011;
      7'b0110111, 7'b0010111: immsrc_o = 3'b100;
      default:                immsrc_o = 3'b000;
    endcase
  end

  // Outputs decode combinationally so reset and the ready cycle act within
  // the same clock: reset aborts an access immediately, FETCH loads on ready.
  assign out_state = rst_i ? S_FETCH : state_q;

  always_comb begin
    mem_req_o   = 1'b0;
    adrsrc_o    = 1'b0;
    memwrite_o  = 1'b0;
    irwrite_o   = 1'b0;
    pcupdate_o  = 1'b0;
    branch_o    = 1'b0;
    regwrite_o  = 1'b0;
    resultsrc_o = 2'b00;
    alusrca_o   = 2'b00;
    alusrcb_o   = 2'b00;
    aluop_o     = 2'b00;
    illegal_o   = 1'b0;
    case (out_state)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alusrcb_o   = 2'b10;
        resultsrc_o = 2'b10;
        irwrite_o   = ready;
        pcupdate_o  = ready;
      end
      S_DECODE: begin
        alusrca_o = 2'b01;
        alusrcb_o = 2'b01;
      end
      S_MEMADR, S_JALR: begin
        alusrca_o = 2'b10;
        alusrcb_o = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        adrsrc_o  = 1'b1;
      end
      S_MEMWB: begin
        resultsrc_o = 2'b01;
        regwrite_o  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_o  = 1'b1;
        adrsrc_o   = 1'b1;
        memwrite_o = 1'b1;
      end
      S_EXECUTER: begin
        alusrca_o = 2'b10;
        aluop_o   = 2'b10;
      end
      S_EXECUTEI: begin
        alusrca_o = 2'b10;
        alusrcb_o = 2'b01;
        aluop_o   = 2'b10;
      end
      S_ALUWB:    regwrite_o = 1'b1;
      S_BEQ: begin
        alusrca_o = 2'b10;
        aluop_o   = 2'b01;
        branch_o  = 1'b1;
      end
      S_JAL: begin
        alusrca_o  = 2'b01;
        alusrcb_o  = 2'b10;
        pcupdate_o = 1'b1;
      end
      S_UPPER: begin
        alusrca_o = op_i[5] ? 2'b11 : 2'b01;
        alusrcb_o = 2'b01;
      end
      S_ILLEGAL:  illegal_o = 1'b1;
      default: ;
    endcase
    if (rst_i) begin
      mem_req_o  = 1'b0;
      memwrite_o = 1'b0;
      irwrite_o  = 1'b0;
      pcupdate_o = 1'b0;
      regwrite_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: three parameterisations checked every cycle
// against an instruction-route model, plus literal state-sequence checks.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_r = 1'b1;
  logic       ready_r = 1'b1;
  logic       ready_c = 1'b0;
  logic [6:0] op_r = 7'b0000011;
  logic [6:0] op_c = 7'b0000011;
  bit         chk_en = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  logic [2:0] mem_req, adrsrc, memwrite, irwrite, pcupdate, branch, regwrite, illegal;
  logic [1:0] resultsrc [3];
  logic [1:0] alusrca [3];
  logic [1:0] alusrcb [3];
  logic [1:0] aluop [3];
  logic [2:0] immsrc [3];
  logic [3:0] state [3];

  always #5 clk = ~clk;

  multicycle_ctrl #(.EN_JALR(1'b1), .EN_UPPER(1'b1), .MEM_WAIT(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst_r), .op_i(op_r), .mem_ready_i(ready_r),
    .mem_req_o(mem_req[0]), .adrsrc_o(adrsrc[0]), .memwrite_o(memwrite[0]),
    .irwrite_o(irwrite[0]), .pcupdate_o(pcupdate[0]), .branch_o(branch[0]),
    .regwrite_o(regwrite[0]), .resultsrc_o(resultsrc[0]), .alusrca_o(alusrca[0]),
    .alusrcb_o(alusrcb[0]), .aluop_o(aluop[0]), .immsrc_o(immsrc[0]),
    .illegal_o(illegal[0]), .state_o(state[0]));

  multicycle_ctrl #(.EN_JALR(1'b0), .EN_UPPER(1'b0), .MEM_WAIT(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst_r), .op_i(op_r), .mem_ready_i(ready_r),
    .mem_req_o(mem_req[1]), .adrsrc_o(adrsrc[1]), .memwrite_o(memwrite[1]),
    .irwrite_o(irwrite[1]), .pcupdate_o(pcupdate[1]), .branch_o(branch[1]),
    .regwrite_o(regwrite[1]), .resultsrc_o(resultsrc[1]), .alusrca_o(alusrca[1]),
    .alusrcb_o(alusrcb[1]), .aluop_o(aluop[1]), .immsrc_o(immsrc[1]),
    .illegal_o(illegal[1]), .state_o(state[1]));

  multicycle_ctrl #(.EN_JALR(1'b1), .EN_UPPER(1'b1), .MEM_WAIT(1'b0)) dut_c (
    .clk_i(clk), .rst_i(rst_r), .op_i(op_c), .mem_ready_i(ready_c),
    .mem_req_o(mem_req[2]), .adrsrc_o(adrsrc[2]), .memwrite_o(memwrite[2]),
    .irwrite_o(irwrite[2]), .pcupdate_o(pcupdate[2]), .branch_o(branch[2]),
    .regwrite_o(regwrite[2]), .resultsrc_o(resultsrc[2]), .alusrca_o(alusrca[2]),
    .alusrcb_o(alusrcb[2]), .aluop_o(aluop[2]), .immsrc_o(immsrc[2]),
    .illegal_o(illegal[2]), .state_o(state[2]));

  // Control word per state: {mem_req,adrsrc,memwrite,irwrite,pcupdate,branch,
  // regwrite,illegal,resultsrc[2],alusrca[2],alusrcb[2],aluop[2]}
  localparam logic [15:0] ROW [16] = '{
    16'b1001_1000_1000_1000,  // FETCH (irwrite/pcupdate gated by ready)
    16'b0000_0000_0001_0100,  // DECODE
    16'b0000_0000_0010_0100,  // MEMADR
    16'b1100_0000_0000_0000,  // MEMREAD
    16'b0000_0010_0100_0000,  // MEMWB
    16'b1110_0000_0000_0000,  // MEMWRITE
    16'b0000_0000_0010_0010,  // EXECUTER
    16'b0000_0000_0010_0110,  // EXECUTEI
    16'b0000_0010_0000_0000,  // ALUWB
    16'b0000_0100_0010_0001,  // BEQ
    16'b0000_1000_0001_1000,  // JAL
    16'b0000_0000_0010_0100,  // JALR
    16'b0000_0000_0000_0100,  // UPPER (alusrca from op)
    16'h0000, 16'h0000,
    16'b0000_0001_0000_0000   // ILLEGAL
  };
  localparam bit EJ [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit EU [3] = '{1'b1, 1'b0, 1'b1};

  int m_state [3] = '{0, 0, 0};
  int route [3][4];
  int rlen [3] = '{0, 0, 0};
  int rpos [3] = '{0, 0, 0};

  function automatic logic rdy_of(int i);
    return (i == 2) ? 1'b1 : ready_r;
  endfunction

  function automatic logic [6:0] op_of(int i);
    return (i == 2) ? op_c : op_r;
  endfunction

  function automatic logic [15:0] exp_ctrl(int st, logic rst, logic rdy, logic [6:0] op);
    logic [15:0] v;
    int s;
    s = rst ? 0 : st;
    v = ROW[s];
    if (s == 0 && !rdy) begin v[12] = 1'b0; v[11] = 1'b0; end
    if (s == 12) v[5:4] = op[5] ? 2'b11 : 2'b01;
    if (rst) begin v[15] = 1'b0; v[13] = 1'b0; v[12] = 1'b0; v[11] = 1'b0; v[9] = 1'b0; end
    return v;
  endfunction

  function automatic logic [2:0] exp_imm(logic [6:0] op);
    case (op)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Post-decode state route of each instruction class.
  task automatic set_route(int i, logic [6:0] op);
    rlen[i] = 2;
    case (op)
      7'b0000011: begin route[i][0] = 2; route[i][1] = 3; route[i][2] = 4; rlen[i] = 3; end
      7'b0100011: begin route[i][0] = 2; route[i][1] = 5; end
      7'b0110011: begin route[i][0] = 6; route[i][1] = 8; end
      7'b0010011: begin route[i][0] = 7; route[i][1] = 8; end
      7'b1100011: begin route[i][0] = 9; rlen[i] = 1; end
      7'b1101111: begin route[i][0] = 10; route[i][1] = 8; end
      7'b1100111: begin
        if (EJ[i]) begin route[i][0] = 11; route[i][1] = 10; route[i][2] = 8; rlen[i] = 3; end
        else begin route[i][0] = 15; rlen[i] = 1; end
      end
      7'b0110111, 7'b0010111: begin
        if (EU[i]) begin route[i][0] = 12; route[i][1] = 8; end
        else begin route[i][0] = 15; rlen[i] = 1; end
      end
      default: begin route[i][0] = 15; rlen[i] = 1; end
    endcase
    rpos[i] = 0;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_r) begin
        m_state[i] = 0;
        rlen[i] = 0;
      end else if (m_state[i] == 15) begin
        m_state[i] = 15;
      end else if ((m_state[i] == 0 || m_state[i] == 3 || m_state[i] == 5) && !rdy_of(i)) begin
        m_state[i] = m_state[i];
      end else begin
        if (m_state[i] == 1) set_route(i, op_of(i));
        if (m_state[i] != 0 && rpos[i] < rlen[i]) begin
          m_state[i] = route[i][rpos[i]];
          rpos[i]++;
        end else if (m_state[i] == 0) m_state[i] = 1;
        else m_state[i] = 0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("ctrl%0d", i),
              {16'h0, mem_req[i], adrsrc[i], memwrite[i], irwrite[i], pcupdate[i],
               branch[i], regwrite[i], illegal[i], resultsrc[i], alusrca[i],
               alusrcb[i], aluop[i]},
              {16'h0, exp_ctrl(m_state[i], rst_r, rdy_of(i), op_of(i))});
        check($sformatf("state%0d", i), {28'h0, state[i]}, m_state[i]);
        check($sformatf("imm%0d", i), {29'h0, immsrc[i]}, {29'h0, exp_imm(op_of(i))});
      end
    end
  end

  task automatic do_reset();
    rst_r = 1'b1;
    ready_r = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_r = 1'b0;
  endtask

  // st: expected dut_a state per cycle, first cycle in the top nibble.
  // rd: ready per cycle, first cycle in bit 15.
  task automatic run(input logic [6:0] op, input string nm, input int n,
                     input logic [63:0] st, input logic [15:0] rd,
                     output int mw, output int rw, output int pc,
                     output logic [1:0] ua, output logic [2:0] ui);
    mw = 0; rw = 0; pc = 0; ua = 2'b00; ui = 3'b000;
    op_r = op;
    for (int k = 0; k < n; k++) begin
      ready_r = rd[15-k];
      @(negedge clk);
      check($sformatf("%s_seq%0d", nm, k), {28'h0, state[0]}, {28'h0, st[63-4*k -: 4]});
      mw += int'(memwrite[0]);
      rw += int'(regwrite[0]);
      pc += int'(pcupdate[0]);
      if (state[0] == 4'd12) begin ua = alusrca[0]; ui = immsrc[0]; end
      @(posedge clk); #1;
    end
  endtask

  int mw, rw, pc;
  logic [1:0] ua;
  logic [2:0] ui;

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_state", {28'h0, state[0]}, 32'd0);
    check("rst_enables", {27'h0, mem_req[0], irwrite[0], pcupdate[0], regwrite[0], memwrite[0]}, 32'd0);
    @(posedge clk); #1;
    rst_r = 1'b0;
    @(negedge clk);
    check("first_fetch", {28'h0, mem_req[0], irwrite[0], pcupdate[0], state[0] == 4'd0}, 32'hf);
    @(posedge clk); #1;
    do_reset();

    // MEM_WAIT=0 instance runs lw with ready held low.
    for (int k = 0; k < 6; k++) begin
      logic [23:0] seq_c;
      seq_c = 24'h012340;
      ready_r = 1'b0;
      @(negedge clk);
      check($sformatf("nowait_seq%0d", k), {28'h0, state[2]}, {28'h0, seq_c[23-4*k -: 4]});
      @(posedge clk); #1;
    end

    run(7'b0000011, "lw", 9, 64'h0001_2334_0000_0000, 16'b0010_0010_0000_0000, mw, rw, pc, ua, ui);
    check("lw_regwrite_cnt", rw, 32'd1);
    run(7'b0100011, "sw", 5, 64'h0125_0000_0000_0000, 16'b1001_0000_0000_0000, mw, rw, pc, ua, ui);
    check("sw_memwrite_cnt", mw, 32'd1);
    check("sw_regwrite_cnt", rw, 32'd0);
    run(7'b0110011, "rtype", 5, 64'h0168_0000_0000_0000, 16'h8000, mw, rw, pc, ua, ui);
    run(7'b0010011, "itype", 5, 64'h0178_0000_0000_0000, 16'h8000, mw, rw, pc, ua, ui);
    run(7'b1100011, "beq", 4, 64'h0190_0000_0000_0000, 16'h8000, mw, rw, pc, ua, ui);
    run(7'b1101111, "jal", 5, 64'h01A8_0000_0000_0000, 16'h8000, mw, rw, pc, ua, ui);
    check("jal_pcupdate_cnt", pc, 32'd2);
    run(7'b1100111, "jalr", 6, 64'h01BA_8000_0000_0000, 16'h8000, mw, rw, pc, ua, ui);
    check("jalr_pcupdate_cnt", pc, 32'd2);
    check("jalr_dis_state", {28'h0, state[1]}, 32'd15);

    for (int k = 0; k < 8; k++) begin
      ready_r = k[0];
      op_r = (k % 3 == 0) ? 7'h00 : ((k % 3 == 1) ? 7'h7f : 7'h55);
      @(negedge clk);
      check("illegal_sticky", {31'h0, illegal[1]}, 32'd1);
      @(posedge clk); #1;
    end
    check("unknown_op_state", {28'h0, state[0]}, 32'd15);

    do_reset();
    run(7'b0010111, "auipc_dis", 5, 64'h01C8_0000_0000_0000, 16'h8000, mw, rw, pc, ua, ui);
    check("upper_dis_state", {28'h0, state[1]}, 32'd15);

    do_reset();
    run(7'b0110111, "lui", 5, 64'h01C8_0000_0000_0000, 16'h8000, mw, rw, pc, ua, ui);
    check("lui_alusrca", ua, 32'd3);
    check("lui_immsrc", ui, 32'd4);
    run(7'b0010111, "auipc", 5, 64'h01C8_0000_0000_0000, 16'h8000, mw, rw, pc, ua, ui);
    check("auipc_alusrca", ua, 32'd1);
    check("auipc_immsrc", ui, 32'd4);

    do_reset();
    run(7'b0100011, "sw_wait", 4, 64'h0125_0000_0000_0000, 16'h8000, mw, rw, pc, ua, ui);
    ready_r = 1'b0;
    @(negedge clk);
    check("memwr_wait", {29'h0, memwrite[0], mem_req[0], state[0] == 4'd5}, 32'h7);
    @(posedge clk); #1;
    rst_r = 1'b1;
    #1;
    check("memwr_abort", {29'h0, memwrite[0], mem_req[0], state[0] == 4'd5}, 32'h1);
    @(posedge clk); #1;
    rst_r = 1'b0;
    @(negedge clk);
    check("abort_fetch", {28'h0, state[0]}, 32'd0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
